// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single external ALU between two requesters. An idle request is
// granted (one-cycle GntX pulse). Its opcode and operands are registered onto
// AluCtrl/AluA/AluB, and the ALU output is captured after WAIT execute cycles.
// The requester then gets a one-cycle DoneX pulse with Result/ZeroOut/Err
// valid. An illegal opcode skips execution and reports Err one cycle after the
// grant.
//
// Optional build macro:
//   ALU_ARB_RR_EN  defined   -> round-robin arbitration with a 1-bit pointer
//                  undefined -> fixed priority, requester 0 always wins
//
// Parameters:
//   n     operand/result width
//   WAIT  execute cycles between operand launch and capture (1..15)
//
// Ports:
//   CLK, Reset_L          clock, asynchronous active-low reset
//   Req0/Req1             requester has an operation pending
//   Ctrl0/Ctrl1           requested opcode
//   A0/B0/A1/B1           requested operands
//   Gnt0/Gnt1             operands accepted this cycle
//   Done0/Done1           Result/ZeroOut/Err valid for that requester
//   Result/ZeroOut/Err    registered response
//   AluCtrl/AluA/AluB     registered drive to the shared ALU
//   AluW/AluZero          shared ALU result and zero flag
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int n    = 64,
    parameter int WAIT = 1
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic         Req0,
    input  logic         Req1,
    input  logic [3:0]   Ctrl0,
    input  logic [3:0]   Ctrl1,
    input  logic [n-1:0] A0,
    input  logic [n-1:0] B0,
    input  logic [n-1:0] A1,
    input  logic [n-1:0] B1,
    output logic         Gnt0,
    output logic         Gnt1,
    output logic         Done0,
    output logic         Done1,
    output logic [n-1:0] Result,
    output logic         ZeroOut,
    output logic         Err,
    output logic [3:0]   AluCtrl,
    output logic [n-1:0] AluA,
    output logic [n-1:0] AluB,
    input  logic [n-1:0] AluW,
    input  logic         AluZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value on the last execute cycle.
    localparam logic [3:0] LAST_CNT = 4'(WAIT - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         owner_q, owner_d;      // requester being served (1 = Req1)
    logic [n-1:0] result_q, result_d;
    logic         zero_q, zero_d;
    logic         err_q, err_d;
    logic [3:0]   alu_ctrl_q, alu_ctrl_d;
    logic [n-1:0] alu_a_q, alu_a_d;
    logic [n-1:0] alu_b_q, alu_b_d;

    logic         any_req;
    logic         grant;
    logic         winner;                // 1 = requester 1 wins
    logic [3:0]   win_ctrl;
    logic [n-1:0] win_a, win_b;
    logic         win_legal;

    assign any_req = Req0 | Req1;
    assign grant   = (state_q == IDLE) && any_req;

`ifdef ALU_ARB_RR_EN
    // ptr_q names the requester favoured on a tie: the one not granted last.
    logic ptr_q, ptr_d;

    assign winner = (Req0 && Req1) ? ptr_q : Req1;

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = ~winner;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign winner = ~Req0;
`endif

    assign win_ctrl  = winner ? Ctrl1 : Ctrl0;
    assign win_a     = winner ? A1 : A0;
    assign win_b     = winner ? B1 : B0;
    // Legal set is 0000..0100, 0110, 0111: top bit clear and not 0101.
    assign win_legal = ~win_ctrl[3] && (win_ctrl != 4'b0101);

    // State and datapath registers.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            alu_ctrl_q <= 4'b0111;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err_d      = err_q;
        alu_ctrl_d = alu_ctrl_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    if (win_legal) begin
                        alu_ctrl_d = win_ctrl;
                        alu_a_d    = win_a;
                        alu_b_d    = win_b;
                        cnt_d      = 4'd0;
                        state_d    = EXEC;
                    end else begin
                        // ALU drive is left untouched for an illegal opcode.
                        result_d = '0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    result_d = AluW;
                    zero_d   = AluZero;
                    err_d    = 1'b0;
                    cnt_d    = 4'd0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs. The grant is gated by Reset_L so that a request held
    // during reset cannot show a grant pulse.
    always_comb begin
        Gnt0  = 1'b0;
        Gnt1  = 1'b0;
        Done0 = 1'b0;
        Done1 = 1'b0;
        if (grant && Reset_L) begin
            Gnt0 = ~winner;
            Gnt1 = winner;
        end
        if (state_q == RESP) begin
            Done0 = ~owner_q;
            Done1 = owner_q;
        end
    end

    assign Result  = result_q;
    assign ZeroOut = zero_q;
    assign Err     = err_q;
    assign AluCtrl = alu_ctrl_q;
    assign AluA    = alu_a_q;
    assign AluB    = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_arbiter. A behavioural ALU is attached to the shared-ALU
// port. Expected responses come from the opcode table, the latency rules and
// a "last granted requester" arbitration model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N    = 64;
    localparam int WAIT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [3:0]   ctrl0, ctrl1;
    logic [N-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, done0, done1;
    logic [N-1:0] result;
    logic         zero_out, err;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_a, alu_b, alu_w;
    logic         alu_zero;

    int total    = 0;
    int bad      = 0;
    int last_gnt = -1;   // arbitration model: requester granted last, -1 after reset

    always #5 clk = ~clk;

    alu_arbiter #(.n(N), .WAIT(WAIT)) dut (
        .CLK(clk), .Reset_L(rst_n),
        .Req0(req0), .Req1(req1), .Ctrl0(ctrl0), .Ctrl1(ctrl1),
        .A0(a0), .B0(b0), .A1(a1), .B1(b1),
        .Gnt0(gnt0), .Gnt1(gnt1), .Done0(done0), .Done1(done1),
        .Result(result), .ZeroOut(zero_out), .Err(err),
        .AluCtrl(alu_ctrl), .AluA(alu_a), .AluB(alu_b),
        .AluW(alu_w), .AluZero(alu_zero)
    );

    function automatic logic [N-1:0] alu_fn(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a << b;
            4'b0100: return a >> b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return '0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b0111};
    endfunction

    function automatic logic [N-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic int pick_winner(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef ALU_ARB_RR_EN
            return (last_gnt == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    // Shared ALU behaviour.
    always_comb begin
        alu_w    = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_zero = (alu_w == '0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from an idle arbiter and records what happened.
    // It does not judge the result. Called and returns at posedge+1 with the
    // arbiter idle.
    task automatic run_op(input int who, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          output int gnt_wait, output int done_lat, output logic [1:0] done_vec,
                          output logic [N-1:0] res, output logic zo, output logic er,
                          output int side_err, output logic [N-1:0] post_res, output logic post_done);
        logic [3:0]   ec;
        logic [N-1:0] ea, eb;
        ec = is_legal(op) ? op : alu_ctrl;
        ea = is_legal(op) ? a : alu_a;
        eb = is_legal(op) ? b : alu_b;
        gnt_wait = -1; done_lat = -1; done_vec = 2'b00;
        res = '0; zo = 1'b0; er = 1'b0; side_err = 0; post_res = '0; post_done = 1'b0;
        if (who == 0) begin req0 = 1'b1; ctrl0 = op; a0 = a; b0 = b; end
        else begin req1 = 1'b1; ctrl1 = op; a1 = a; b1 = b; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                gnt_wait = ((who == 0) ? (gnt0 && !gnt1) : (gnt1 && !gnt0)) ? k : -2;
                break;
            end
            next_cycle();
        end
        next_cycle();
        // Inputs are only valid in the grant cycle; scramble them afterwards.
        req0 = 1'b0; req1 = 1'b0;
        ctrl0 = 4'($urandom()); ctrl1 = 4'($urandom());
        a0 = rand64(); b0 = rand64(); a1 = rand64(); b1 = rand64();
        for (int c = 1; c <= WAIT + 3; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) side_err++;
            if (alu_ctrl !== ec || alu_a !== ea || alu_b !== eb) side_err++;
            if (done0 || done1) begin
                done_lat = c; done_vec = {done1, done0};
                res = result; zo = zero_out; er = err;
                break;
            end
            next_cycle();
        end
        next_cycle();
        @(negedge clk);
        post_res = result; post_done = done0 | done1 | gnt0 | gnt1;
        next_cycle();
        if (gnt_wait >= 0) last_gnt = who;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b0; ctrl0 = 4'b0010; ctrl1 = 4'b0000;
        a0 = 64'd5; b0 = 64'd7; a1 = '0; b1 = '0;
        #12;
        total++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin bad++; $display("FAIL reset_handshake: got %b, expected 0000", {gnt0, gnt1, done0, done1}); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result: got %0h, expected 0", result); end
        total++; if (zero_out !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b, expected 0", zero_out); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, expected 0", err); end
        total++; if (alu_ctrl !== 4'b0111) begin bad++; $display("FAIL reset_aluctrl: got %b, expected 0111", alu_ctrl); end
        total++; if (alu_a !== '0 || alu_b !== '0) begin bad++; $display("FAIL reset_aluab: got %0h/%0h, expected 0/0", alu_a, alu_b); end
        next_cycle();
        req0 = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        last_gnt = -1;
        next_cycle();
        $display("reset: checked");
    endtask

    task automatic test_add_example();
        int gw, dl, se; logic [1:0] dv; logic [N-1:0] res, pr; logic zo, er, pd;
        run_op(0, 4'b0010, 64'd5, 64'd7, gw, dl, dv, res, zo, er, se, pr, pd);
        $display("add: who=0 ctrl=0010 lat=%0d res=%0h", dl, res);
        total++; if (gw !== 0) begin bad++; $display("FAIL add_gnt: got %0d, expected 0", gw); end
        total++; if (dl !== WAIT + 1) begin bad++; $display("FAIL add_latency: got %0d, expected %0d", dl, WAIT + 1); end
        total++; if (dv !== 2'b01) begin bad++; $display("FAIL add_done: got %b, expected 01", dv); end
        total++; if (res !== 64'd12) begin bad++; $display("FAIL add_result: got %0h, expected c", res); end
        total++; if (zo !== 1'b0 || er !== 1'b0) begin bad++; $display("FAIL add_flags: got %b%b, expected 00", zo, er); end
        total++; if (se !== 0) begin bad++; $display("FAIL add_alu_hold: got %0d, expected 0", se); end
        total++; if (pr !== 64'd12 || pd !== 1'b0) begin bad++; $display("FAIL add_result_hold: got %0h/%b, expected c/0", pr, pd); end
    endtask

    task automatic test_sub_zero();
        int gw, dl, se; logic [1:0] dv; logic [N-1:0] res, pr; logic zo, er, pd;
        run_op(1, 4'b0110, 64'h1234, 64'h1234, gw, dl, dv, res, zo, er, se, pr, pd);
        $display("sub: who=1 ctrl=0110 lat=%0d res=%0h", dl, res);
        total++; if (gw !== 0) begin bad++; $display("FAIL sub_gnt: got %0d, expected 0", gw); end
        total++; if (dl !== WAIT + 1) begin bad++; $display("FAIL sub_latency: got %0d, expected %0d", dl, WAIT + 1); end
        total++; if (dv !== 2'b10) begin bad++; $display("FAIL sub_done: got %b, expected 10", dv); end
        total++; if (res !== '0) begin bad++; $display("FAIL sub_result: got %0h, expected 0", res); end
        total++; if (zo !== 1'b1 || er !== 1'b0) begin bad++; $display("FAIL sub_flags: got %b%b, expected 10", zo, er); end
        total++; if (se !== 0) begin bad++; $display("FAIL sub_alu_hold: got %0d, expected 0", se); end
    endtask

    task automatic test_illegal();
        int gw, dl, se; logic [1:0] dv; logic [N-1:0] res, pr, a, b; logic zo, er, pd;
        a = rand64(); b = rand64();
        run_op(0, 4'b0000, a, b, gw, dl, dv, res, zo, er, se, pr, pd);
        total++; if (res !== (a & b)) begin bad++; $display("FAIL and_result: got %0h, expected %0h", res, a & b); end
        run_op(0, 4'b0101, rand64(), rand64(), gw, dl, dv, res, zo, er, se, pr, pd);
        $display("illegal: who=0 ctrl=0101 lat=%0d res=%0h err=%b", dl, res, er);
        total++; if (gw !== 0) begin bad++; $display("FAIL ill_gnt: got %0d, expected 0", gw); end
        total++; if (dl !== 1) begin bad++; $display("FAIL ill_latency: got %0d, expected 1", dl); end
        total++; if (dv !== 2'b01) begin bad++; $display("FAIL ill_done: got %b, expected 01", dv); end
        total++; if (res !== '0 || zo !== 1'b1 || er !== 1'b1) begin bad++; $display("FAIL ill_resp: got %0h/%b/%b, expected 0/1/1", res, zo, er); end
        total++; if (alu_ctrl !== 4'b0000 || alu_a !== a || alu_b !== b) begin bad++; $display("FAIL ill_alu_unchanged: got %b %0h %0h, expected 0000 %0h %0h", alu_ctrl, alu_a, alu_b, a, b); end
        total++; if (se !== 0) begin bad++; $display("FAIL ill_side: got %0d, expected 0", se); end
    endtask

    task automatic test_random();
        int gw, dl, se, who, exp_lat; logic [1:0] dv; logic [3:0] op;
        logic [N-1:0] res, pr, a, b, exp_res; logic zo, er, pd, exp_zo, exp_er;
        for (int i = 0; i < 30; i++) begin
            who = int'($urandom_range(0, 1));
            op  = 4'($urandom_range(0, 15));
            a   = rand64();
            b   = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 70)) : rand64();
            if ($urandom_range(0, 7) == 0) b = a;
            exp_lat = is_legal(op) ? WAIT + 1 : 1;
            exp_res = is_legal(op) ? alu_fn(op, a, b) : '0;
            exp_zo  = is_legal(op) ? (exp_res == '0) : 1'b1;
            exp_er  = !is_legal(op);
            run_op(who, op, a, b, gw, dl, dv, res, zo, er, se, pr, pd);
            $display("rand %0d: who=%0d ctrl=%b lat=%0d res=%0h z=%b e=%b", i, who, op, dl, res, zo, er);
            total++; if (gw !== 0) begin bad++; $display("FAIL rand_gnt: got %0d, expected 0", gw); end
            total++; if (dl !== exp_lat) begin bad++; $display("FAIL rand_latency: got %0d, expected %0d", dl, exp_lat); end
            total++; if (dv !== ((who == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rand_done: got %b, expected who=%0d", dv, who); end
            total++; if (res !== exp_res) begin bad++; $display("FAIL rand_result: got %0h, expected %0h", res, exp_res); end
            total++; if (zo !== exp_zo || er !== exp_er) begin bad++; $display("FAIL rand_flags: got %b%b, expected %b%b", zo, er, exp_zo, exp_er); end
            total++; if (se !== 0) begin bad++; $display("FAIL rand_side: got %0d, expected 0", se); end
            total++; if (pr !== exp_res || pd !== 1'b0) begin bad++; $display("FAIL rand_hold: got %0h/%b, expected %0h/0", pr, pd, exp_res); end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        int ndone, last_done_c, gnt_c, pend, w, exp_w; logic [N-1:0] exp_res;
        ctrl0 = 4'b0010; a0 = rand64(); b0 = rand64();
        ctrl1 = 4'b0001; a1 = rand64(); b1 = rand64();
        req0 = 1'b1; req1 = 1'b1;
        ndone = 0; last_done_c = -1; gnt_c = 0; pend = -1;
        for (int c = 0; c < 60 && ndone < 6; c++) begin
            @(negedge clk);
            total++; if (gnt0 && gnt1) begin bad++; $display("FAIL b2b_dual_gnt: got 11, expected one-hot"); end
            if (gnt0 || gnt1) begin
                w = gnt1 ? 1 : 0;
                exp_w = pick_winner(1'b1, 1'b1);
                $display("b2b: cycle=%0d grant=%0d", c, w);
                total++; if (w !== exp_w) begin bad++; $display("FAIL b2b_winner: got %0d, expected %0d", w, exp_w); end
                total++; if (c !== last_done_c + 1) begin bad++; $display("FAIL b2b_gap: got %0d, expected %0d", c, last_done_c + 1); end
                last_gnt = w; pend = w; gnt_c = c;
            end
            if (done0 || done1) begin
                exp_res = (pend == 1) ? alu_fn(4'b0001, a1, b1) : alu_fn(4'b0010, a0, b0);
                total++; if ({done1, done0} !== ((pend == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL b2b_done: got %b, expected owner %0d", {done1, done0}, pend); end
                total++; if (result !== exp_res) begin bad++; $display("FAIL b2b_result: got %0h, expected %0h", result, exp_res); end
                total++; if (c !== gnt_c + WAIT + 1) begin bad++; $display("FAIL b2b_latency: got %0d, expected %0d", c, gnt_c + WAIT + 1); end
                last_done_c = c;
                ndone++;
            end
            next_cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        total++; if (ndone !== 6) begin bad++; $display("FAIL b2b_count: got %0d, expected 6", ndone); end
        next_cycle();
    endtask

    task automatic test_reset_exec();
        int gw, dl, se, spur; logic found; logic [1:0] dv; logic [N-1:0] res, pr, a, b; logic zo, er, pd;
        req1 = 1'b1; ctrl1 = 4'b0010; a1 = rand64() | 64'd1; b1 = rand64();
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (gnt1) begin found = 1'b1; break; end
            next_cycle();
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rstx_gnt: got %b, expected 1", found); end
        next_cycle();
        req1 = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        #1;
        total++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin bad++; $display("FAIL rstx_handshake: got %b, expected 0000", {gnt0, gnt1, done0, done1}); end
        total++; if (result !== '0 || zero_out !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rstx_resp: got %0h/%b/%b, expected 0/0/0", result, zero_out, err); end
        total++; if (alu_ctrl !== 4'b0111 || alu_a !== '0 || alu_b !== '0) begin bad++; $display("FAIL rstx_alu: got %b %0h %0h, expected 0111 0 0", alu_ctrl, alu_a, alu_b); end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        last_gnt = -1;
        spur = 0;
        for (int c = 0; c < WAIT + 3; c++) begin
            @(negedge clk);
            if (done0 || done1 || gnt0 || gnt1) spur++;
            next_cycle();
        end
        total++; if (spur !== 0) begin bad++; $display("FAIL rstx_no_done: got %0d, expected 0", spur); end
        a = rand64(); b = rand64();
        run_op(1, 4'b0110, a, b, gw, dl, dv, res, zo, er, se, pr, pd);
        $display("after reset: who=1 ctrl=0110 lat=%0d res=%0h", dl, res);
        total++; if (gw !== 0 || dv !== 2'b10) begin bad++; $display("FAIL rstx_next_gnt: got %0d/%b, expected 0/10", gw, dv); end
        total++; if (dl !== WAIT + 1) begin bad++; $display("FAIL rstx_next_latency: got %0d, expected %0d", dl, WAIT + 1); end
        total++; if (res !== a - b || er !== 1'b0) begin bad++; $display("FAIL rstx_next_result: got %0h/%b, expected %0h/0", res, er, a - b); end
    endtask

    initial begin
        test_reset();
        test_add_example();
        test_sub_zero();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter n, default 64, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter WAIT, default 1, range 1-15, giving the number of EXEC cycles between operand launch and result capture.
REQ-003 The block SHALL provide CLK  input  1  rising-edge clock, the only clock in the block.
REQ-004 The block SHALL provide Reset_L  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL provide Req0, Req1  input  1 each  requester has an operation pending.
REQ-006 The block SHALL provide Ctrl0, Ctrl1  input  4 each  requested ALU opcode.
REQ-007 The block SHALL provide A0, B0, A1, B1  input  n each  requested operands.
REQ-008 The block SHALL provide Gnt0, Gnt1  output  1 each  one-cycle pulse; operands accepted this cycle.
REQ-009 The block SHALL provide Done0, Done1  output  1 each  one-cycle pulse; Result/ZeroOut/Err valid for that requester.
REQ-010 The block SHALL provide Result  output  n, ZeroOut  output  1 and Err  output  1, all registered.
REQ-011 The block SHALL provide AluCtrl  output  4 and AluA, AluB  output  n, all registered, driving the shared ALU.
REQ-012 The block SHALL provide AluW  input  n and AluZero  input  1, taken from the shared ALU.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC and RESP and SHALL enter IDLE on reset.
REQ-014 In IDLE with any ReqX high, the FSM SHALL select one winner per REQ-027, pulse GntX for one cycle, register CtrlX/AX/BX into AluCtrl/AluA/AluB, and go to EXEC on the next edge.
REQ-015 In IDLE with no ReqX high, the FSM SHALL stay in IDLE and all Gnt and Done outputs SHALL be 0.
REQ-016 Legal opcodes SHALL be 0000 AND, 0001 OR, 0010 ADD, 0011 LSL, 0100 LSR, 0110 SUB and 0111 PassB; any other opcode is illegal.
REQ-017 EXEC SHALL last exactly WAIT cycles, counted by a 4-bit counter, with AluCtrl/AluA/AluB held stable throughout.
REQ-018 On the final EXEC cycle, the block SHALL capture AluW into Result and AluZero into ZeroOut, set Err=0, and go to RESP.
REQ-019 When the granted opcode is illegal, the block SHALL skip EXEC, go from IDLE directly to RESP, and set Result=0, ZeroOut=1, Err=1; AluCtrl/AluA/AluB SHALL be left unchanged.
REQ-020 In RESP, the block SHALL pulse DoneX for the granted requester only, for exactly one cycle, and then go to IDLE.
REQ-021 Latency SHALL be: Gnt at cycle T, Done at T+WAIT+1 for a legal opcode and at T+1 for an illegal one; back-to-back grants SHALL be no closer than Done+1.
REQ-022 Result, ZeroOut and Err SHALL hold their value from Done until the next capture.
REQ-023 ReqX SHALL be ignored outside IDLE, and a ReqX still high in the cycle after its Done SHALL be treated as a new request.
REQ-024 Gnt0 and Gnt1 SHALL never be high in the same cycle, and likewise Done0 and Done1.
REQ-025 ReqX/CtrlX/AX/BX SHALL only need to be valid in the Gnt cycle; later changes SHALL not affect the operation in flight.

Reset
REQ-026 While Reset_L is low, the block SHALL immediately force: state IDLE, counter 0, Gnt*=0, Done*=0, Result=0, ZeroOut=0, Err=0, AluCtrl=0111, AluA=0, AluB=0, priority pointer=requester 0; any operation in flight SHALL be discarded and SHALL produce no Done.

Configuration
REQ-027 With macro ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer favours the requester not granted last, toggles after each grant, and is 0 after reset; without the macro, arbitration SHALL be fixed priority with Req0 always winning and no pointer register.

Verification
REQ-028 Req0 only, Ctrl0=0010, A0=5, B0=7, WAIT=1 -> Gnt0 at T, AluCtrl=0010 from T+1, Done0 at T+2 with Result=12, ZeroOut=0, Err=0.
REQ-029 Req1 only, Ctrl1=0110, A1=B1=64'h1234 -> Done1 at T+WAIT+1 with Result=0, ZeroOut=1; Done0 never high.
REQ-030 Req0 and Req1 held high continuously, ALU_ARB_RR_EN defined -> grants alternate 0,1,0,1; with the macro undefined -> Gnt0 only, Gnt1 never high.
REQ-031 Req0 with Ctrl0=0101 -> Done0 at T+1 with Result=0, ZeroOut=1, Err=1, and AluCtrl unchanged.
REQ-032 Reset_L driven low during EXEC (WAIT=3), then released -> outputs equal the REQ-026 values at once, no Done pulse, and the next Req1 is granted normally.
